// File: rtl/cm_counter_mod.sv
// Presettable modulo-MODULUS up/down counter slice with cascadable ripple carry.
// q and wrap update one edge after the inputs; rco is combinational; no backpressure.
module cm_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_below_max;

    assign w_step      = enp & ent;
    assign w_at_max    = (r_q == LP_MAX);
    assign w_at_zero   = (r_q == '0);
    assign w_below_max = (r_q < LP_MAX);

    // Out-of-range counts (above LP_MAX) fall through to the self-correcting branches, which never flag a wrap.
    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_q_nxt = '0;
        end else if (load) begin
            w_q_nxt = d;
        end else if (w_step) begin
            if (up) begin
                if (w_below_max) begin
                    w_q_nxt = r_q + WIDTH'(1);
                end else begin
                    w_q_nxt    = '0;
                    w_wrap_nxt = w_at_max;
                end
            end else begin
                if (w_at_zero) begin
                    w_q_nxt    = LP_MAX;
                    w_wrap_nxt = 1'b1;
                end else if (w_below_max || w_at_max) begin
                    w_q_nxt = r_q - WIDTH'(1);
                end else begin
                    w_q_nxt = LP_MAX;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign rco  = ent & (up ? w_at_max : w_at_zero);

endmodule
